reg_file_sc: RTL and testbench
==============================

# reg_file_sc

Parametrised multi-register file with a scoreboard, the next generation of the small core register file. It adds configurable width and depth, a hardwired-zero register 0, and a post-reset clear sweep that zeroes every register and reports `ready`. A per-register pending scoreboard tracks issued writes whose results have not yet returned. It sits between decode/issue (read ports, claims) and writeback (write port).

## Interface
- `DATA_WIDTH`, 8, register width in bits
- `ADDR_WIDTH`, 3, register index width; `NUM_REGS = 2**ADDR_WIDTH` (derived, not overridable)

- `clk`  in  1  clock; all state updates on the rising edge
- `rst`  in  1  reset, synchronous, active-high
- `wr_en`  in  1  writeback strobe
- `rd`  in  ADDR_WIDTH  writeback register index
- `din`  in  DATA_WIDTH  writeback data
- `claim_en`  in  1  issue strobe; marks `claim_addr` pending
- `claim_addr`  in  ADDR_WIDTH  destination register of the issued instruction
- `rs1`, `rs2`  in  ADDR_WIDTH  read indices
- `r1`, `r2`  out  DATA_WIDTH  read data, combinational
- `p1`, `p2`  out  1  pending flag for `rs1` / `rs2`, combinational
- `ready`  out  1  register file is cleared and accepting traffic

## Operation
- FSM with two states.
  - **CLEAR**: entered on `rst`.
  - **RUN**: normal operation.
- **Reset.** While `rst`=1:
  - state=CLEAR, clear pointer `ptr`=1
  - all pending bits = 0, `ready`=0
  - register contents are untouched.
- **CLEAR.**
  - Each cycle with `rst`=0: reg[`ptr`] <= 0 and `ptr` increments.
  - On the edge that clears reg[NUM_REGS-1]: state <= RUN and `ready` <= 1.
  - `wr_en` and `claim_en` are ignored; writes and claims are dropped, not queued.
  - `r1`, `r2`, `p1`, `p2` are forced to 0.
- **RUN, write.** `wr_en`=1 with `rd`≠0: reg[`rd`] <= `din` and pend[`rd`] <= 0. A write to `rd`=0 is discarded.
- **RUN, claim.** `claim_en`=1 with `claim_addr`≠0: pend[`claim_addr`] <= 1. A claim of register 0 is discarded.
- **Simultaneous claim and write to the same index:** data is written and the pending bit ends at 1 (claim wins, new producer).
- **Reads.**
  - `r1` = 0 if `rs1`=0, else reg[`rs1`]; `r2` is identical for `rs2`.
  - `p1` = pend[`rs1`], `p2` = pend[`rs2`]; register 0 is never pending.
- **Reset mid-operation:** returns to CLEAR, restarts the sweep from `ptr`=1 and clears all pending bits on the `rst` edge.
- `ptr` is ADDR_WIDTH bits wide and never wraps. The exit compare is at NUM_REGS-1.

## Timing
- Write latency: 1 cycle. Data is visible on `r1`/`r2` the cycle after the `wr_en` edge (with bypass disabled).
- Claim latency: 1 cycle to `p1`/`p2`.
- Clear sweep: exactly NUM_REGS-1 cycles after `rst` deasserts. `ready` is high from the (NUM_REGS-1)th rising edge with `rst`=0 onward (7 edges for the default).
- Reset values of outputs:
  - `ready`=0
  - `p1`=`p2`=0
  - `r1`=`r2`=0, forced during CLEAR.
- Read ports are purely combinational from `rs1`/`rs2`, register state and, with bypass, `wr_en`/`rd`/`din`. There are no read-enable handshakes.

## Configuration
- `REG_FILE_BYPASS_EN` defined:
  - In RUN, when `wr_en`=1, `rd`≠0 and `rd`==`rs1`: `r1`=`din` in the same cycle, and `p1` reads 0 unless a same-cycle claim targets `rs1`.
  - The same rule applies to `r2`/`p2`.
- Not defined: no forwarding. Readers see the stored value and the stored pending bit, i.e. old data during the write cycle.

## Test plan
- Sweep: preload reg3=8'hA5, pulse `rst` 1 cycle → `ready`=0 for 7 edges, then 1; reading `rs1`=3 returns 8'h00.
- Write/read, zero register: `wr_en`, `rd`=5, `din`=8'h3C → next cycle `rs1`=5 gives 8'h3C. Write 8'hFF to `rd`=0 → `rs2`=0 still gives 8'h00.
- Scoreboard: claim 4 → next cycle `p1`=1 with `rs1`=4. Write `rd`=4 → next cycle `p1`=0. Claim and write 4 in the same cycle → `p1`=1 and data updated.
- Dropped in CLEAR: `wr_en` `rd`=2 `din`=8'h11 and `claim_en` 2 during the sweep → after `ready`, reg2=0 and `p1`=0 for `rs1`=2.
- Bypass: `wr_en` `rd`=6 `din`=8'h5A with `rs1`=6 → with the macro, `r1`=8'h5A in the same cycle; without it, `r1` shows the old value.
- Reset mid-operation: pending bits set and `rst` asserted → `p1`/`p2`=0, `ready`=0, and the full 7-cycle sweep repeats.

Source files
------------

// File: rtl/reg_file_sc.sv
// ============================================================================
// Module   : reg_file_sc
// Purpose  : Register file with hardwired-zero r0, post-reset clear sweep and
//            per-register pending scoreboard. Optional write-to-read
//            forwarding when REG_FILE_BYPASS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_sc #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [ADDR_WIDTH-1:0] rd_i,
  input  logic [DATA_WIDTH-1:0] din_i,
  input  logic                  claim_en_i,
  input  logic [ADDR_WIDTH-1:0] claim_addr_i,
  input  logic [ADDR_WIDTH-1:0] rs1_i,
  input  logic [ADDR_WIDTH-1:0] rs2_i,
  output logic [DATA_WIDTH-1:0] r1_o,
  output logic [DATA_WIDTH-1:0] r2_o,
  output logic                  p1_o,
  output logic                  p2_o,
  output logic                  ready_o
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
  logic [NUM_REGS-1:0]     pend_q, pend_d;
  logic                    ready_q, ready_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];

  logic                    we;
  logic [ADDR_WIDTH-1:0]   waddr;
  logic [DATA_WIDTH-1:0]   wdata;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    pend_d  = pend_q;
    ready_d = ready_q;
    we      = 1'b0;
    waddr   = rd_i;
    wdata   = din_i;
    case (state_q)
      ST_CLEAR: begin
        // Traffic is dropped here; the write port is owned by the sweep.
        we    = 1'b1;
        waddr = ptr_q;
        wdata = '0;
        if (ptr_q == LAST_IDX) begin
          state_d = ST_RUN;
          ready_d = 1'b1;
        end else begin
          ptr_d = ptr_q + ADDR_WIDTH'(1);
        end
      end
      ST_RUN: begin
        if (wr_en_i && (rd_i != '0)) begin
          we           = 1'b1;
          pend_d[rd_i] = 1'b0;
        end
        // Claim applied after the write so a same-index claim wins.
        if (claim_en_i && (claim_addr_i != '0)) begin
          pend_d[claim_addr_i] = 1'b1;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= ADDR_WIDTH'(1);
      pend_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
    end
  end

  // Storage has no reset; contents survive rst until the sweep zeroes them.
  always_ff @(posedge clk) begin
    if (!rst && we) begin
      regs_q[waddr] <= wdata;
    end
  end

  always_comb begin
    r1_o = (rs1_i == '0) ? '0 : regs_q[rs1_i];
    r2_o = (rs2_i == '0) ? '0 : regs_q[rs2_i];
    p1_o = pend_q[rs1_i];
    p2_o = pend_q[rs2_i];
`ifdef REG_FILE_BYPASS_EN
    if (state_q == ST_RUN && wr_en_i && (rd_i != '0)) begin
      if (rd_i == rs1_i) begin
        r1_o = din_i;
        p1_o = claim_en_i && (claim_addr_i == rs1_i);
      end
      if (rd_i == rs2_i) begin
        r2_o = din_i;
        p2_o = claim_en_i && (claim_addr_i == rs2_i);
      end
    end
`endif
    if (state_q != ST_RUN) begin
      r1_o = '0;
      r2_o = '0;
      p1_o = 1'b0;
      p2_o = 1'b0;
    end
  end

  assign ready_o = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_sc.sv
// ============================================================================
// Module   : tb_reg_file_sc
// Purpose  : Directed self-checking bench for reg_file_sc (default 8x8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_sc;

  logic       clk;
  logic       rst;
  logic       wr_en_i;
  logic [2:0] rd_i;
  logic [7:0] din_i;
  logic       claim_en_i;
  logic [2:0] claim_addr_i;
  logic [2:0] rs1_i;
  logic [2:0] rs2_i;
  logic [7:0] r1_o;
  logic [7:0] r2_o;
  logic       p1_o;
  logic       p2_o;
  logic       ready_o;

  int n_checks = 0;
  int n_errors = 0;

  reg_file_sc #(
    .DATA_WIDTH(8),
    .ADDR_WIDTH(3)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en_i     (wr_en_i),
    .rd_i        (rd_i),
    .din_i       (din_i),
    .claim_en_i  (claim_en_i),
    .claim_addr_i(claim_addr_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .r1_o        (r1_o),
    .r2_o        (r2_o),
    .p1_o        (p1_o),
    .p2_o        (p2_o),
    .ready_o     (ready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle reset pulse, then count the sweep edges; optionally push
  // traffic at register 2 that must be dropped.
  task automatic do_sweep(input bit inject);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_ready", {31'd0, ready_o}, 32'd0);
    for (int i = 1; i <= 7; i++) begin
      if (inject) begin
        wr_en_i      = 1'b1;
        rd_i         = 3'd2;
        din_i        = 8'h11;
        claim_en_i   = 1'b1;
        claim_addr_i = 3'd2;
      end
      tick();
      check($sformatf("sweep_ready_e%0d", i), {31'd0, ready_o}, (i == 7) ? 32'd1 : 32'd0);
    end
    wr_en_i    = 1'b0;
    claim_en_i = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; wr_en_i = 1'b0; rd_i = '0; din_i = '0;
    claim_en_i = 1'b0; claim_addr_i = '0; rs1_i = 3'd3; rs2_i = 3'd5;
    tick();
    tick();
    check("reset_ready", {31'd0, ready_o}, 32'd0);
    check("reset_p1", {31'd0, p1_o}, 32'd0);
    check("reset_p2", {31'd0, p2_o}, 32'd0);
    check("reset_r1", {24'd0, r1_o}, 32'd0);
    check("reset_r2", {24'd0, r2_o}, 32'd0);
    do_sweep(1'b0);

    // Preload reg3 then verify the sweep zeroes it and drops traffic.
    wr_en_i = 1'b1; rd_i = 3'd3; din_i = 8'hA5;
    tick();
    wr_en_i = 1'b0; rs1_i = 3'd3; #1;
    check("preload_r3", {24'd0, r1_o}, 32'hA5);
    do_sweep(1'b1);
    rs1_i = 3'd3; #1;
    check("swept_r3", {24'd0, r1_o}, 32'h00);
    rs1_i = 3'd2; #1;
    check("dropped_wr_r2", {24'd0, r1_o}, 32'h00);
    check("dropped_claim_p2", {31'd0, p1_o}, 32'd0);

    // Write / read and the zero register.
    wr_en_i = 1'b1; rd_i = 3'd5; din_i = 8'h3C;
    tick();
    wr_en_i = 1'b0; rs1_i = 3'd5; #1;
    check("wr5_r1", {24'd0, r1_o}, 32'h3C);
    wr_en_i = 1'b1; rd_i = 3'd0; din_i = 8'hFF;
    tick();
    wr_en_i = 1'b0; rs2_i = 3'd0; #1;
    check("r0_zero", {24'd0, r2_o}, 32'h00);
    check("r5_kept", {24'd0, r1_o}, 32'h3C);

    // Scoreboard.
    claim_en_i = 1'b1; claim_addr_i = 3'd4;
    tick();
    claim_en_i = 1'b0; rs1_i = 3'd4; #1;
    check("claim4_p1", {31'd0, p1_o}, 32'd1);
    wr_en_i = 1'b1; rd_i = 3'd4; din_i = 8'h77;
    tick();
    wr_en_i = 1'b0; #1;
    check("wb4_p1", {31'd0, p1_o}, 32'd0);
    check("wb4_r1", {24'd0, r1_o}, 32'h77);
    wr_en_i = 1'b1; rd_i = 3'd4; din_i = 8'h99;
    claim_en_i = 1'b1; claim_addr_i = 3'd4;
    tick();
    wr_en_i = 1'b0; claim_en_i = 1'b0; #1;
    check("both4_p1", {31'd0, p1_o}, 32'd1);
    check("both4_r1", {24'd0, r1_o}, 32'h99);
    claim_en_i = 1'b1; claim_addr_i = 3'd0;
    tick();
    claim_en_i = 1'b0; rs2_i = 3'd0; #1;
    check("claim0_p2", {31'd0, p2_o}, 32'd0);

    // Same-cycle read of a register being written (and pending).
    wr_en_i = 1'b1; rd_i = 3'd6; din_i = 8'h12;
    tick();
    wr_en_i = 1'b0;
    claim_en_i = 1'b1; claim_addr_i = 3'd6;
    tick();
    claim_en_i = 1'b0;
    wr_en_i = 1'b1; rd_i = 3'd6; din_i = 8'h5A; rs1_i = 3'd6; #1;
`ifdef REG_FILE_BYPASS_EN
    check("byp_r1", {24'd0, r1_o}, 32'h5A);
    check("byp_p1", {31'd0, p1_o}, 32'd0);
`else
    check("nobyp_r1", {24'd0, r1_o}, 32'h12);
    check("nobyp_p1", {31'd0, p1_o}, 32'd1);
`endif
    tick();
    wr_en_i = 1'b0; #1;
    check("wr6_r1", {24'd0, r1_o}, 32'h5A);
    check("wr6_p1", {31'd0, p1_o}, 32'd0);

    // Reset mid-operation with pending bits set.
    claim_en_i = 1'b1; claim_addr_i = 3'd3;
    tick();
    claim_en_i = 1'b0; rs1_i = 3'd4; rs2_i = 3'd3; #1;
    check("mid_p1_pre", {31'd0, p1_o}, 32'd1);
    check("mid_p2_pre", {31'd0, p2_o}, 32'd1);
    do_sweep(1'b0);
    rs1_i = 3'd4; rs2_i = 3'd3; #1;
    check("mid_p1_post", {31'd0, p1_o}, 32'd0);
    check("mid_p2_post", {31'd0, p2_o}, 32'd0);
    check("mid_r1_post", {24'd0, r1_o}, 32'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
